// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and single-cycle bypass for divide corner cases.
module muldiv_sequencer #(
    parameter int Inst_Size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           func3,
    input  logic [Inst_Size-1:0] rs1_data,
    input  logic [Inst_Size-1:0] rs2_data,
    output logic [Inst_Size-1:0] result,
    output logic                 busy,
    output logic                 done,
    output logic                 stall
);
    localparam int W  = Inst_Size;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    op;
    logic          sgn_a, sgn_b;
    logic [W-1:0]  hi, lo, opnd;
    logic [CW-1:0] cnt;

    logic          is_div, a_signed, b_signed, a_neg, b_neg, div0, ovf, bypass;
    logic [W-1:0]  a_mag, b_mag, bypass_res, fix_res;
    logic [W:0]    mul_sum, div_t, div_diff;
    logic          div_ge;
    logic [2*W-1:0] prod_fix;

    // Operand decode on the live inputs; only consumed in IDLE.
    always_comb begin
        is_div   = func3[2];
        a_signed = is_div ? ~func3[0] : (func3 == 3'b001 || func3 == 3'b010);
        b_signed = is_div ? ~func3[0] : (func3 == 3'b001);
        a_neg    = a_signed & rs1_data[W-1];
        b_neg    = b_signed & rs2_data[W-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        div0     = is_div && (rs2_data == '0);
        ovf      = is_div && !func3[0] && (rs1_data == MOST_NEG) && (rs2_data == '1);
        bypass   = div0 | ovf;
        if (func3[1]) bypass_res = div0 ? rs1_data : '0;
        else          bypass_res = div0 ? '1 : MOST_NEG;
    end

    // One iteration step: multiply adds into hi and shifts right; divide shifts left and trial-subtracts.
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_t    = {hi, lo[W-1]};
        div_diff = div_t - {1'b0, opnd};
        div_ge   = div_t >= {1'b0, opnd};
        prod_fix = (sgn_a ^ sgn_b) ? -{hi, lo} : {hi, lo};
        case (op)
            3'b000:                 fix_res = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*W-1:W];
            3'b100, 3'b101:         fix_res = (sgn_a ^ sgn_b) ? -lo : lo;
            default:                fix_res = sgn_a ? -hi : hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = bypass ? DONE : CALC;
            CALC: if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op     <= '0;
            sgn_a  <= 1'b0;
            sgn_b  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op    <= func3;
                    sgn_a <= a_neg;
                    sgn_b <= b_neg;
                    cnt   <= '0;
                    hi    <= '0;
                    if (is_div) begin
                        lo   <= a_mag;
                        opnd <= b_mag;
                    end else begin
                        lo   <= b_mag;
                        opnd <= a_mag;
                    end
                    if (bypass) result <= bypass_res;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op[2]) begin
                        hi <= div_ge ? div_diff[W-1:0] : div_t[W-1:0];
                        lo <= {lo[W-2:0], div_ge};
                    end else begin
                        hi <= mul_sum[W:1];
                        lo <= {mul_sum[0], lo[W-1:1]};
                    end
                end
                FIX: result <= fix_res;
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign stall = start & ~done;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed RV32M results, latency, bypass and reset abort.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  func3;
    logic [31:0] rs1_data, rs2_data, result;
    logic        busy, done, stall;
    int          n_vec = 0;
    int          n_err = 0;

    muldiv_sequencer #(.Inst_Size(32)) dut (
        .clk(clk), .reset(reset), .start(start), .func3(func3),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .result(result), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one op from IDLE; counts cycles after the accepting edge until done.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input bit scramble);
        int  lat;
        bit  got;
        logic [31:0] prev;
        @(negedge clk);
        func3 = f; rs1_data = a; rs2_data = b; start = 1'b1;
        #1 chk({tag, ".stall_req"}, {31'b0, stall}, 32'd1);
        @(posedge clk);
        lat = 0; got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, ".busy1"}, {31'b0, busy}, 32'd1);
            if (scramble && k == 3) begin
                rs1_data = ~rs1_data; rs2_data = rs2_data + 32'd5; func3 = f ^ 3'b101;
            end
            if (done) begin got = 1'b1; lat = k; end
        end
        if (!got) begin
            chk({tag, ".timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, ".lat"}, lat, exp_lat);
            chk({tag, ".res"}, result, exp_res);
            chk({tag, ".stall_done"}, {31'b0, stall}, 32'd0);
        end
        prev  = result;
        start = 1'b0;
        @(negedge clk);
        chk({tag, ".idle"}, {30'b0, busy, done}, 32'd0);
        chk({tag, ".hold"}, result, prev);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; func3 = '0; rs1_data = '0; rs2_data = '0;
        @(negedge clk);
        start = 1'b1;
        #1 chk("rst.stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("rst.result", result, 32'd0);
        chk("rst.busy_done", {30'b0, busy, done}, 32'd0);
        reset = 1'b0;

        run_op("mul_neg",   3'b000, 32'd7,         32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, 1'b1);
        run_op("mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 1'b0);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'd2,         34, 32'hFFFF_FFFF, 1'b0);
        run_op("div_neg",   3'b100, 32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFD, 1'b1);
        run_op("rem_neg",   3'b110, 32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_divneg",3'b110, 32'd7,         32'hFFFF_FFFE, 34, 32'd1,         1'b0);
        run_op("divu",      3'b101, 32'd100,       32'd7,         34, 32'd14,        1'b0);
        run_op("remu",      3'b111, 32'd100,       32'd7,         34, 32'd2,         1'b0);
        run_op("divu_z",    3'b101, 32'h0000_1234, 32'd0,          1, 32'hFFFF_FFFF, 1'b0);
        run_op("remu_z",    3'b111, 32'h0000_1234, 32'd0,          1, 32'h0000_1234, 1'b0);
        run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF,  1, 32'd0,         1'b0);
        run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF,  1, 32'h8000_0000, 1'b0);

        // Abort a DIV in its tenth cycle.
        @(negedge clk);
        func3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd3; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) @(negedge clk);
        chk("abort.busy_pre", {31'b0, busy}, 32'd1);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("abort.busy_done", {30'b0, busy, done}, 32'd0);
        chk("abort.result", result, 32'd0);
        reset = 1'b0;
        run_op("mul_after", 3'b000, 32'd3, 32'd5, 34, 32'h0000_000F, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter Inst_Size, default 32, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request for an M-extension operation; held high by the core until done.
REQ-005 SHALL have port func3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_data  input  Inst_Size  first operand (dividend / multiplicand).
REQ-007 SHALL have port rs2_data  input  Inst_Size  second operand (divisor / multiplier).
REQ-008 SHALL have port result  output  Inst_Size  operation result, registered.
REQ-009 SHALL have port busy  output  1  high while state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid in that cycle.
REQ-011 SHALL have port stall  output  1  combinational start AND NOT done; freezes PC and register writeback in the core.

Function
REQ-012 SHALL implement the FSM with states IDLE, CALC, FIX and DONE.
REQ-013 In IDLE with start=1, SHALL latch func3 and operand magnitudes, record operand signs, clear the iteration counter, and enter CALC.
REQ-014 Operand interpretation SHALL be: MULH, DIV, REM both signed; MULHSU rs1 signed, rs2 unsigned; MUL, MULHU, DIVU, REMU both unsigned magnitudes.
REQ-015 In CALC, multiply SHALL perform one shift-add step per cycle into a 2*Inst_Size accumulator.
REQ-016 In CALC, divide SHALL perform one restoring shift-subtract step per cycle, producing quotient and remainder.
REQ-017 CALC SHALL last exactly Inst_Size cycles: counter 0..Inst_Size-1, exit to FIX when the counter reaches Inst_Size-1.
REQ-018 FIX SHALL apply sign correction (1 cycle) and load result:
- MUL: low word of the product.
- MULH/MULHSU/MULHU: high word of the product.
- DIV/DIVU: quotient negated if the operand signs differ (signed ops only).
- REM/REMU: remainder carrying the dividend's sign.
REQ-019 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-020 Latency: start sampled at edge N produces done=1 in cycle N+Inst_Size+2 (34 for Inst_Size=32).
REQ-021 Divide-by-zero SHALL bypass CALC and FIX: IDLE goes directly to DONE, with done in cycle N+1.
- DIV/DIVU result SHALL be all ones.
- REM/REMU result SHALL be rs1_data.
REQ-022 Signed overflow (DIV/REM, rs1=most-negative, rs2=all ones) SHALL bypass to DONE in cycle N+1.
- DIV result SHALL be the most-negative value.
- REM result SHALL be 0.
REQ-023 start SHALL be ignored in CALC, FIX and DONE.
- Operand or func3 changes during an operation SHALL NOT affect the result.
- A new operation SHALL be accepted only from IDLE, so back-to-back ops have at least one IDLE cycle between them.
REQ-024 result SHALL hold its last value in IDLE until the next FIX/DONE load.
REQ-025 All arithmetic SHALL be modulo 2^Inst_Size per word; no exceptions or flags are raised.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE from any state, including mid-CALC, aborting the operation.
REQ-027 After reset: result=0, busy=0, done=0, counter=0, accumulators=0.
REQ-028 stall SHALL be 1 in any cycle where start=1 and done=0, including during reset.
REQ-029 reset SHALL take priority over start in the same cycle.

Verification
REQ-030 MUL rs1=7, rs2=0xFFFFFFFD, start at N -> done at N+34, result=0xFFFFFFEB, busy high N+1..N+34.
REQ-031 MULH 0x80000000 x 0x80000000 -> result=0x40000000.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; each done at N+34.
REQ-034 DIVU 0x1234 / 0 -> done at N+1, result=0xFFFFFFFF.
REQ-035 REM 0x80000000 / 0xFFFFFFFF -> done at N+1, result=0.
REQ-036 Reset at cycle N+10 of a DIV -> busy=0, done=0, result=0 next cycle; a new MUL 3x5 then completes with 0xF at its N'+34.
